// File: rtl/fpga_link_receiver.sv
// rtl/fpga_link_receiver.sv - Bit-serial four-phase handshake link receiver with frame checking and stall timeout.
module fpga_link_receiver #(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  send,
    input  logic                  data_bit,
    input  logic                  finish,
    output logic                  acknowledge,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  received,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_WAIT, S_BIT_ACK, S_FIN_ACK, S_RESYNC} state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [SYNC_STAGES-1:0]  r_send_sync;
    logic [SYNC_STAGES-1:0]  r_data_sync;
    logic [SYNC_STAGES-1:0]  r_fin_sync;
    logic [CW-1:0]           r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [TW-1:0]           r_timer;
    logic                    w_send_s;
    logic                    w_data_s;
    logic                    w_finish_s;
    logic                    w_cnt_full;
    logic                    w_timer_run;
    logic                    w_timer_hit;
    logic                    w_capture;
    logic                    w_good;
    logic                    w_bad;
    logic                    w_clr_cnt;
    logic                    w_ack_d;

    // All link pins cross into the clock domain through equal-depth chains so data stays aligned with send.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_send_sync <= '0;
            r_data_sync <= '0;
            r_fin_sync  <= '0;
        end else begin
            r_send_sync <= {r_send_sync[SYNC_STAGES-2:0], send};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], data_bit};
            r_fin_sync  <= {r_fin_sync[SYNC_STAGES-2:0], finish};
        end
    end

    assign w_send_s    = r_send_sync[SYNC_STAGES-1];
    assign w_data_s    = r_data_sync[SYNC_STAGES-1];
    assign w_finish_s  = r_fin_sync[SYNC_STAGES-1];
    assign w_cnt_full  = (r_bit_cnt == CW'(DATA_WIDTH));
    assign w_timer_run = (r_state == S_BIT_ACK) || (r_state == S_FIN_ACK) ||
                         ((r_state == S_WAIT) && (r_bit_cnt != '0));
    assign w_timer_hit = w_timer_run && (r_timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_WAIT;
        else       r_state <= w_next_state;
    end

    // Link events take priority over a coincident timeout so a live transmitter is never aborted.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        w_clr_cnt    = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (w_finish_s) begin
                    w_next_state = S_FIN_ACK;
                    w_good       = w_cnt_full;
                    w_bad        = !w_cnt_full;
                    w_clr_cnt    = 1'b1;
                end else if (w_send_s) begin
                    w_next_state = S_BIT_ACK;
                    w_capture    = !w_cnt_full;
                    w_bad        = w_cnt_full;
                    w_clr_cnt    = w_cnt_full;
                end else if (w_timer_hit) begin
                    w_next_state = S_RESYNC;
                    w_bad        = 1'b1;
                    w_clr_cnt    = 1'b1;
                end
            end
            S_BIT_ACK: begin
                if (!w_send_s) begin
                    w_next_state = S_WAIT;
                end else if (w_timer_hit) begin
                    w_next_state = S_RESYNC;
                    w_bad        = 1'b1;
                    w_clr_cnt    = 1'b1;
                end
            end
            S_FIN_ACK: begin
                if (!w_finish_s && !w_send_s) begin
                    w_next_state = S_WAIT;
                end else if (w_timer_hit) begin
                    w_next_state = S_RESYNC;
                    w_bad        = 1'b1;
                    w_clr_cnt    = 1'b1;
                end
            end
            default: begin
                if (!w_send_s && !w_finish_s) w_next_state = S_WAIT;
            end
        endcase
    end

    always_comb begin
        w_ack_d = (w_next_state == S_BIT_ACK) || (w_next_state == S_FIN_ACK);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acknowledge <= 1'b0;
            received    <= 1'b0;
            frame_error <= 1'b0;
            data_out    <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
        end else begin
            acknowledge <= w_ack_d;
            received    <= w_good;
            frame_error <= w_bad;
            if (w_good) data_out <= r_shift;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (w_capture && (r_bit_cnt == CW'(i))) r_shift[i] <= w_data_s;
            end
            if (w_clr_cnt)      r_bit_cnt <= '0;
            else if (w_capture) r_bit_cnt <= r_bit_cnt + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || (w_next_state != r_state) || w_capture || !w_timer_run) r_timer <= '0;
        else                                                                 r_timer <= r_timer + TW'(1);
    end

    assign busy = (r_state != S_WAIT) || (r_bit_cnt != '0);

endmodule
